// File: rtl/noc_mem_arbiter_pkg.sv
// rtl/noc_mem_arbiter_pkg.sv - shared types for the CPU/NoC memory arbiter
package noc_mem_arbiter_pkg;

   typedef logic [31:0] memword;

   typedef enum logic [1:0] {
      IDLE,
      OWN0,
      OWN1
   } arb_state_t;

endpackage

// File: rtl/noc_mem_arbiter.sv
// rtl/noc_mem_arbiter.sv - two-port (CPU, NoC DMA) memory arbiter with burst lock
// Grants are decoded combinationally from the current requests; read data returns one cycle later.
module noc_mem_arbiter
   import noc_mem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_BURST = 8
) (
   input  logic             clock_in,
   input  logic             reset_in,
   input  logic [1:0]       req_in,
   input  logic [1:0]       lock_in,
   input  logic [1:0][3:0]  wb_in,
   input  memword [1:0]     addr_in,
   input  memword [1:0]     data_in,
   output logic [1:0]       gnt_out,
   output logic [1:0]       rvalid_out,
   output memword           rdata_out,
   output logic             mem_en_out,
   output memword           mem_addr_out,
   output memword           mem_data_out,
   output logic [3:0]       mem_wb_out,
   input  memword           mem_data_in
);

   localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);

   arb_state_t state;
   logic       last_owner;
   logic [7:0] burst_cnt;
   logic [1:0] rvalid_q;

   logic       owner_valid;
   logic       owner;
   logic       keep;
   logic [1:0] gnt_c;
   logic       sel;

   assign owner_valid = (state != IDLE);
   assign owner       = (state == OWN1);
   assign keep        = owner_valid && req_in[owner] && lock_in[owner] && (burst_cnt < MAX_CNT);

   // A saturated burst falls through to round-robin, so the other port wins if it is asking.
   always_comb begin
      gnt_c = '0;
      if (keep)
         gnt_c[owner] = 1'b1;
      else if (&req_in)
         gnt_c[~last_owner] = 1'b1;
      else
         gnt_c = req_in;
   end

   assign gnt_out      = reset_in ? gnt_c : 2'b00;
   assign sel          = gnt_out[1];
   assign mem_en_out   = |gnt_out;
   assign mem_addr_out = mem_en_out ? addr_in[sel] : '0;
   assign mem_data_out = mem_en_out ? data_in[sel] : '0;
   assign mem_wb_out   = mem_en_out ? wb_in[sel]   : 4'b0000;

   always_ff @(posedge clock_in or negedge reset_in) begin
      if (!reset_in) begin
         state      <= IDLE;
         last_owner <= 1'b1;
         burst_cnt  <= 8'd0;
         rvalid_q   <= 2'b00;
      end else begin
         rvalid_q <= gnt_out & {2{wb_in[sel] == 4'b0000}};
         if (mem_en_out) begin
            state      <= sel ? OWN1 : OWN0;
            last_owner <= sel;
            if (owner_valid && (owner == sel))
               burst_cnt <= (burst_cnt < MAX_CNT) ? burst_cnt + 8'd1 : burst_cnt;
            else
               burst_cnt <= 8'd1;
         end else begin
            state     <= IDLE;
            burst_cnt <= 8'd0;
         end
      end
   end

   assign rvalid_out = rvalid_q;
   assign rdata_out  = (|rvalid_q) ? mem_data_in : '0;

endmodule

// File: tb/tb_noc_mem_arbiter.sv
// tb/tb_noc_mem_arbiter.sv - directed and randomized checks of noc_mem_arbiter against a reference model
module tb_noc_mem_arbiter;
   import noc_mem_arbiter_pkg::*;

   localparam int MB = 8;

   logic            clock_in = 1'b0;
   logic            reset_in = 1'b0;
   logic [1:0]      req_in = '0;
   logic [1:0]      lock_in = '0;
   logic [1:0][3:0] wb_in = '0;
   memword [1:0]    addr_in = '0;
   memword [1:0]    data_in = '0;
   logic [1:0]      gnt_out;
   logic [1:0]      rvalid_out;
   memword          rdata_out;
   logic            mem_en_out;
   memword          mem_addr_out;
   memword          mem_data_out;
   logic [3:0]      mem_wb_out;
   memword          mem_data_in = '0;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: owner (-1 = none), run length, last port served, port expecting read data.
   int m_owner, m_cnt, m_last, m_rv;

   noc_mem_arbiter #(.MAX_BURST(MB)) dut (
      .clock_in(clock_in), .reset_in(reset_in), .req_in(req_in), .lock_in(lock_in),
      .wb_in(wb_in), .addr_in(addr_in), .data_in(data_in), .gnt_out(gnt_out),
      .rvalid_out(rvalid_out), .rdata_out(rdata_out), .mem_en_out(mem_en_out),
      .mem_addr_out(mem_addr_out), .mem_data_out(mem_data_out), .mem_wb_out(mem_wb_out),
      .mem_data_in(mem_data_in)
   );

   always #5 clock_in = ~clock_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner = -1; m_cnt = 0; m_last = 1; m_rv = -1;
   endtask

   task automatic do_reset();
      @(posedge clock_in);
      #1;
      reset_in = 1'b0;
      req_in = 2'b11;
      #2;
      check("rst_gnt", 32'(gnt_out), 32'd0);
      check("rst_rvalid", 32'(rvalid_out), 32'd0);
      check("rst_rdata", rdata_out, 32'd0);
      check("rst_mem_en", 32'(mem_en_out), 32'd0);
      check("rst_mem_addr", mem_addr_out, 32'd0);
      req_in = 2'b00;
      #4;
      reset_in = 1'b1;
      model_reset();
   endtask

   task automatic cycle(input logic [1:0] r, input logic [1:0] l, input logic [1:0][3:0] w,
                        input logic [1:0][31:0] a, input logic [1:0][31:0] d, input logic [31:0] md);
      int g;
      logic [1:0] eg, erv;
      @(posedge clock_in);
      #1;
      req_in = r; lock_in = l; wb_in = w; addr_in = a; data_in = d; mem_data_in = md;
      #2;
      if (m_owner >= 0 && r[m_owner] && l[m_owner] && m_cnt < MB) g = m_owner;
      else if (r == 2'b11) g = 1 - m_last;
      else if (r[0]) g = 0;
      else if (r[1]) g = 1;
      else g = -1;
      eg  = (g < 0) ? 2'b00 : 2'(1 << g);
      erv = (m_rv < 0) ? 2'b00 : 2'(1 << m_rv);
      check("gnt", 32'(gnt_out), 32'(eg));
      check("rvalid", 32'(rvalid_out), 32'(erv));
      check("rdata", rdata_out, (m_rv < 0) ? 32'd0 : md);
      check("mem_en", 32'(mem_en_out), (g < 0) ? 32'd0 : 32'd1);
      check("mem_addr", mem_addr_out, (g < 0) ? 32'd0 : a[g]);
      check("mem_data", mem_data_out, (g < 0) ? 32'd0 : d[g]);
      check("mem_wb", 32'(mem_wb_out), (g < 0) ? 32'd0 : 32'(w[g]));
      if (g >= 0) begin
         m_cnt   = (g == m_owner) ? ((m_cnt < MB) ? m_cnt + 1 : m_cnt) : 1;
         m_owner = g;
         m_last  = g;
         m_rv    = (w[g] == 4'd0) ? g : -1;
      end else begin
         m_owner = -1; m_cnt = 0; m_rv = -1;
      end
   endtask

   initial begin
      logic [1:0] seq32 [4];
      logic [1:0][31:0] a, d;
      logic [1:0][3:0]  w;
      seq32[0] = 2'b01; seq32[1] = 2'b10; seq32[2] = 2'b01; seq32[3] = 2'b10;
      model_reset();
      repeat (2) @(posedge clock_in);
      #3;
      check("init_gnt", 32'(gnt_out), 32'd0);
      check("init_rvalid", 32'(rvalid_out), 32'd0);
      check("init_mem_wb", 32'(mem_wb_out), 32'd0);
      #2;
      reset_in = 1'b1;

      // all-idle requests
      for (int i = 0; i < 4; i++) begin
         cycle(2'b00, 2'b11, '0, {32'h44, 32'h33}, {32'h22, 32'h11}, 32'hFFFF_FFFF);
         check("idle_mem_en", 32'(mem_en_out), 32'd0);
      end

      // single CPU read with one-cycle return
      cycle(2'b01, 2'b00, '0, {32'h0, 32'h10}, '0, 32'h0);
      check("rd_gnt", 32'(gnt_out), 32'h1);
      cycle(2'b00, 2'b00, '0, '0, '0, 32'hCAFE_BABE);
      check("rd_rvalid", 32'(rvalid_out), 32'h1);
      check("rd_rdata", rdata_out, 32'hCAFE_BABE);

      // round-robin alternation without lock
      do_reset();
      for (int i = 0; i < 4; i++) begin
         cycle(2'b11, 2'b00, '0, {32'hB0 + i, 32'hA0 + i}, '0, $urandom);
         check("rr_seq", 32'(gnt_out), 32'(seq32[i]));
      end

      // locked burst forced off after MAX_BURST grants
      do_reset();
      for (int i = 0; i <= MB; i++) begin
         cycle(2'b11, 2'b01, '0, '0, '0, $urandom);
         check("burst_seq", 32'(gnt_out), (i < MB) ? 32'h1 : 32'h2);
      end

      // NoC write: no read data afterwards
      w = '0; w[1] = 4'hF;
      cycle(2'b10, 2'b00, w, {32'h20, 32'h0}, {32'h1234_5678, 32'h0}, 32'h0);
      check("wr_wb", 32'(mem_wb_out), 32'hF);
      check("wr_data", mem_data_out, 32'h1234_5678);
      cycle(2'b00, 2'b00, '0, '0, '0, 32'h5555_AAAA);
      check("wr_no_rvalid", 32'(rvalid_out), 32'h0);

      // reset during the read-return cycle
      cycle(2'b10, 2'b00, '0, {32'h30, 32'h0}, '0, 32'h0);
      do_reset();
      cycle(2'b11, 2'b00, '0, '0, '0, 32'h0);
      check("post_rst_gnt", 32'(gnt_out), 32'h1);

      // randomized traffic with heavy locking and occasional reset
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 59) == 0) do_reset();
         w[0] = ($urandom_range(0, 1) != 0) ? 4'(($urandom_range(1, 15))) : 4'h0;
         w[1] = ($urandom_range(0, 1) != 0) ? 4'(($urandom_range(1, 15))) : 4'h0;
         a[0] = $urandom; a[1] = $urandom; d[0] = $urandom; d[1] = $urandom;
         cycle(2'($urandom_range(0, 3)),
               ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3)),
               w, a, d, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
